// File: rtl/conv_2d_controller.sv
// Sequencer for a conv_2d engine: loads the kernel from kernel memory, streams the
// image in raster order, then tags each conv_2d result with its output (row, col).
module conv_2d_controller #(
  parameter int unsigned IMG_W    = 28,
  parameter int unsigned KER_W    = 5,
  parameter int unsigned CONV_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pause,
  output logic        busy,
  output logic        done,
  output logic [4:0]  kmem_addr,
  input  logic [15:0] kmem_data,
  output logic [9:0]  imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] kernal_input,
  output logic        kernal_input_valid,
  output logic        kernal_complete,
  output logic [15:0] image_input_pixel,
  output logic        image_input_valid,
  output logic        image_complete,
  input  logic [31:0] conv_output_pixel,
  output logic [31:0] out_pixel,
  output logic        out_valid,
  output logic [4:0]  out_row,
  output logic [4:0]  out_col
);

  localparam int unsigned KTOT = KER_W * KER_W;
  localparam int unsigned ITOT = IMG_W * IMG_W;
  localparam int unsigned KCW  = $clog2(KTOT + 1);
  localparam int unsigned ICW  = $clog2(ITOT + 1);
  localparam int unsigned KAW  = 5;
  localparam int unsigned IAW  = 10;
  localparam int unsigned CW   = 5;
  localparam int unsigned FCW  = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;

  typedef enum logic [2:0] {IDLE, LOAD_K, K_DONE, STREAM, FLUSH, DONE} state_e;

  state_e         state_q, state_d;
  logic           k_issue_c, i_issue_c, k_cmpl_c, i_cmpl_c, win_c;
  logic [KCW-1:0] kcnt_q;
  logic [ICW-1:0] icnt_q;
  logic [FCW-1:0] flush_q;
  logic [CW-1:0]  irow_q, icol_q, arow_q, acol_q;
  logic [KAW-1:0] kaddr_q;
  logic [IAW-1:0] iaddr_q;
  logic           k_issue_q, i_issue_q, kvalid_q, ivalid_q;
  logic           kcmpl_q, icmpl_q, busy_q, done_q;
  logic [CONV_LAT:0] dv_q;
  logic [CW-1:0]  drow_q [CONV_LAT+1];
  logic [CW-1:0]  dcol_q [CONV_LAT+1];

  // Next-state and per-cycle issue/complete decisions
  always_comb begin
    state_d   = state_q;
    k_issue_c = 1'b0;
    i_issue_c = 1'b0;
    k_cmpl_c  = 1'b0;
    i_cmpl_c  = 1'b0;
    unique case (state_q)
      IDLE:   if (start) state_d = LOAD_K;
      LOAD_K: begin
        if (!pause) begin
          k_issue_c = 1'b1;
          if (kcnt_q == KCW'(KTOT - 1)) state_d = K_DONE;
        end
      end
      // Wait for the last kernel beat to drain, then pulse complete
      K_DONE: begin
        if (!k_issue_q) begin
          k_cmpl_c = 1'b1;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        if (icnt_q != ICW'(ITOT)) begin
          if (!pause) i_issue_c = 1'b1;
        end else if (!i_issue_q) begin
          i_cmpl_c = 1'b1;
          state_d  = FLUSH;
        end
      end
      FLUSH:   if (flush_q == FCW'(CONV_LAT - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A beat lands inside the valid output window once a full kernel fits
  assign win_c = i_issue_q && (arow_q >= CW'(KER_W - 1)) && (acol_q >= CW'(KER_W - 1));

  // State register, address counters, beat pipeline and output tag delay line
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      kcnt_q    <= '0;
      icnt_q    <= '0;
      flush_q   <= '0;
      irow_q    <= '0;
      icol_q    <= '0;
      arow_q    <= '0;
      acol_q    <= '0;
      kaddr_q   <= '0;
      iaddr_q   <= '0;
      k_issue_q <= 1'b0;
      i_issue_q <= 1'b0;
      kvalid_q  <= 1'b0;
      ivalid_q  <= 1'b0;
      kcmpl_q   <= 1'b0;
      icmpl_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dv_q      <= '0;
      for (int i = 0; i <= int'(CONV_LAT); i++) begin
        drow_q[i] <= '0;
        dcol_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      busy_q    <= (state_q != IDLE);
      done_q    <= (state_q == DONE);
      k_issue_q <= k_issue_c;
      i_issue_q <= i_issue_c;
      kvalid_q  <= k_issue_q;
      ivalid_q  <= i_issue_q;
      kcmpl_q   <= k_cmpl_c;
      icmpl_q   <= i_cmpl_c;
      flush_q   <= (state_q == FLUSH) ? flush_q + FCW'(1) : '0;

      if (state_q == IDLE) begin
        kcnt_q <= '0;
        icnt_q <= '0;
        irow_q <= '0;
        icol_q <= '0;
      end else begin
        if (k_issue_c) begin
          kaddr_q <= KAW'(kcnt_q);
          kcnt_q  <= kcnt_q + KCW'(1);
        end
        if (i_issue_c) begin
          iaddr_q <= IAW'(icnt_q);
          arow_q  <= irow_q;
          acol_q  <= icol_q;
          icnt_q  <= icnt_q + ICW'(1);
          if (icol_q == CW'(IMG_W - 1)) begin
            icol_q <= '0;
            irow_q <= irow_q + CW'(1);
          end else begin
            icol_q <= icol_q + CW'(1);
          end
        end
      end

      dv_q[0]   <= win_c;
      drow_q[0] <= win_c ? arow_q - CW'(KER_W - 1) : '0;
      dcol_q[0] <= win_c ? acol_q - CW'(KER_W - 1) : '0;
      for (int i = 1; i <= int'(CONV_LAT); i++) begin
        dv_q[i]   <= dv_q[i-1];
        drow_q[i] <= drow_q[i-1];
        dcol_q[i] <= dcol_q[i-1];
      end
    end
  end

  // Memory read data is forwarded in the cycle it is qualified, zero otherwise
  assign kernal_input       = kvalid_q ? kmem_data : '0;
  assign image_input_pixel  = ivalid_q ? imem_data : '0;
  assign out_pixel          = dv_q[CONV_LAT] ? conv_output_pixel : '0;
  assign kernal_input_valid = kvalid_q;
  assign image_input_valid  = ivalid_q;
  assign kernal_complete    = kcmpl_q;
  assign image_complete     = icmpl_q;
  assign out_valid          = dv_q[CONV_LAT];
  assign out_row            = drow_q[CONV_LAT];
  assign out_col            = dcol_q[CONV_LAT];
  assign kmem_addr          = kaddr_q;
  assign imem_addr          = iaddr_q;
  assign busy               = busy_q;
  assign done               = done_q;

endmodule

// File: tb/tb_conv_2d_controller.sv
// Bench for conv_2d_controller: memories and a fixed-latency conv_2d stand-in,
// with per-cycle expectations derived from the run's event schedule.
module tb_conv_2d_controller;

  localparam int IMG_W    = 28;
  localparam int KER_W    = 5;
  localparam int CONV_LAT = 2;
  localparam int NBEAT    = IMG_W * IMG_W;
  localparam int NK       = KER_W * KER_W;
  localparam int NOUT     = (IMG_W - KER_W + 1) * (IMG_W - KER_W + 1);
  localparam int WIN      = 1100;

  logic        clk = 1'b0;
  logic        rst, start, pause;
  logic        busy, done;
  logic [4:0]  kmem_addr;
  logic [15:0] kmem_data;
  logic [9:0]  imem_addr;
  logic [15:0] imem_data;
  logic [15:0] kernal_input;
  logic        kernal_input_valid, kernal_complete;
  logic [15:0] image_input_pixel;
  logic        image_input_valid, image_complete;
  logic [31:0] conv_output_pixel;
  logic [31:0] out_pixel;
  logic        out_valid;
  logic [4:0]  out_row, out_col;

  logic [15:0] kmem [32];
  logic [15:0] imem [1024];
  logic [31:0] conv_pipe;

  int n_checks = 0;
  int n_pass   = 0;
  int beat_at  [WIN];
  int iaddr_at [WIN];

  conv_2d_controller #(.IMG_W(IMG_W), .KER_W(KER_W), .CONV_LAT(CONV_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .busy(busy), .done(done),
    .kmem_addr(kmem_addr), .kmem_data(kmem_data), .imem_addr(imem_addr), .imem_data(imem_data),
    .kernal_input(kernal_input), .kernal_input_valid(kernal_input_valid),
    .kernal_complete(kernal_complete), .image_input_pixel(image_input_pixel),
    .image_input_valid(image_input_valid), .image_complete(image_complete),
    .conv_output_pixel(conv_output_pixel), .out_pixel(out_pixel), .out_valid(out_valid),
    .out_row(out_row), .out_col(out_col)
  );

  always #5 clk = ~clk;

  // Latency-1 memories and a two-stage conv_2d stand-in tagging the pixel
  always @(posedge clk) begin
    kmem_data         <= kmem[kmem_addr];
    imem_data         <= imem[imem_addr];
    conv_pipe         <= {16'hA5A5, image_input_pixel};
    conv_output_pixel <= conv_pipe;
  end

  // Run one convolution and compare every output every cycle against the schedule.
  // Pause is sampled at relative edges p_at..p_at+p_len-1 (inside STREAM);
  // rst_at>0 stops the run by raising rst for edge rst_at+1.
  task automatic run_case(input string name, input int p_at, input int p_len,
                          input int restart_at, input int rst_at);
    int e, last_v, d_done, d_end, k, n_ov, n_done;
    logic        x_busy, x_done, x_kv, x_kc, x_iv, x_ic, x_ov;
    logic [15:0] x_kd, o_kd, x_id, o_id;
    logic [4:0]  x_ka, o_ka, x_or, o_or, x_oc, o_oc;
    logic [9:0]  x_ia, o_ia;
    logic [31:0] x_op, o_op;
    logic [95:0] obs, expv;
    e = 0;
    for (int i = 0; i < WIN; i++) begin
      beat_at[i]  = -1;
      iaddr_at[i] = -1;
    end
    for (int b = 0; b < NBEAT; b++) begin
      e = 28 + b + ((p_len > 0 && 28 + b >= p_at) ? p_len : 0);
      iaddr_at[e]  = b;
      beat_at[e+1] = b;
    end
    last_v = e + 1;
    d_done = last_v + 4;
    d_end  = (rst_at > 0) ? rst_at : d_done + 3;
    n_ov   = 0;
    n_done = 0;
    @(negedge clk);
    start = 1'b1;
    pause = 1'b0;
    for (int d = 0; d <= d_end; d++) begin
      @(negedge clk);
      x_busy = (d >= 1 && d <= d_done);
      x_done = (d == d_done);
      x_kv   = (d >= 2 && d <= NK + 1);
      x_kc   = (d == NK + 2);
      x_iv   = (beat_at[d] >= 0);
      x_ic   = (d == last_v + 1);
      k      = (d >= 2) ? beat_at[d-2] : -1;
      x_ov   = (k >= 0) && (k / IMG_W >= KER_W - 1) && (k % IMG_W >= KER_W - 1);
      x_kd = x_kv ? kmem[d-2] : 16'h0;
      o_kd = x_kv ? kernal_input : 16'h0;
      x_id = x_iv ? imem[beat_at[d]] : 16'h0;
      o_id = x_iv ? image_input_pixel : 16'h0;
      x_ka = (d >= 1 && d <= NK) ? 5'(d - 1) : 5'h0;
      o_ka = (d >= 1 && d <= NK) ? kmem_addr : 5'h0;
      x_ia = (iaddr_at[d] >= 0) ? 10'(iaddr_at[d]) : 10'h0;
      o_ia = (iaddr_at[d] >= 0) ? imem_addr : 10'h0;
      x_op = x_ov ? {16'hA5A5, imem[k]} : 32'h0;
      o_op = x_ov ? out_pixel : 32'h0;
      x_or = x_ov ? 5'(k / IMG_W - (KER_W - 1)) : 5'h0;
      o_or = x_ov ? out_row : 5'h0;
      x_oc = x_ov ? 5'(k % IMG_W - (KER_W - 1)) : 5'h0;
      o_oc = x_ov ? out_col : 5'h0;
      expv = {x_busy, x_done, x_kv, x_kc, x_iv, x_ic, x_ov, x_kd, x_id, x_ka, x_ia, x_op, x_or, x_oc};
      obs  = {busy, done, kernal_input_valid, kernal_complete, image_input_valid,
              image_complete, out_valid, o_kd, o_id, o_ka, o_ia, o_op, o_or, o_oc};
      n_checks++;
      if (obs !== expv)
        $display("FAIL %s cycle %0d: got %h expected %h", name, d, obs, expv);
      else
        n_pass++;
      if (out_valid === 1'b1) n_ov++;
      if (done === 1'b1) n_done++;
      start = (d + 1 == restart_at);
      pause = (p_len > 0 && d + 1 >= p_at && d + 1 < p_at + p_len);
      if (rst_at > 0 && d == rst_at) begin
        rst   = 1'b1;
        start = 1'b1;
        pause = 1'b1;
      end
    end
    if (rst_at == 0) begin
      n_checks++;
      if (n_ov !== NOUT) $display("FAIL %s out_valid count: got %0d expected %0d", name, n_ov, NOUT);
      else n_pass++;
      n_checks++;
      if (n_done !== 1) $display("FAIL %s done count: got %0d expected 1", name, n_done);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    logic [95:0] obs;
    rst   = 1'b1;
    start = 1'b1;
    pause = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      obs = {busy, done, kernal_input_valid, kernal_complete, image_input_valid, image_complete,
             out_valid, kernal_input, image_input_pixel, kmem_addr, imem_addr, out_pixel, out_row, out_col};
      n_checks++;
      if (obs !== 96'h0) $display("FAIL reset_state step %0d: got %h expected 0", i, obs);
      else n_pass++;
      if (i == 0) begin
        rst   = 1'b0;
        start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 1024; i++) imem[i] = 16'(i);
    run_case("basic", 0, 0, 0, 0);
  endtask

  task automatic test_pause();
    for (int i = 0; i < 1024; i++) imem[i] = 16'($urandom);
    run_case("pause10", 28 + $urandom_range(20, 700), 10, 0, 0);
    run_case("pause_rand", 28 + $urandom_range(1, 750), $urandom_range(1, 20), 0, 0);
  endtask

  task automatic test_restart_ignored();
    run_case("restart", 0, 0, 100, 0);
  endtask

  task automatic test_mid_reset();
    logic [95:0] obs;
    run_case("pre_reset", 0, 0, 0, 400);
    for (int d = 401; d <= 408; d++) begin
      @(negedge clk);
      obs = {busy, done, kernal_input_valid, kernal_complete, image_input_valid, image_complete,
             out_valid, kernal_input, image_input_pixel, kmem_addr, imem_addr, out_pixel, out_row, out_col};
      n_checks++;
      if (obs !== 96'h0) $display("FAIL mid_reset cycle %0d: got %h expected 0", d, obs);
      else n_pass++;
      rst   = 1'b0;
      start = 1'b0;
      pause = 1'b0;
    end
    run_case("after_reset", 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) kmem[i] = 16'($urandom);
    for (int i = 0; i < 1024; i++) imem[i] = 16'h0;
    test_reset();
    test_basic();
    test_pause();
    test_restart_ignored();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/conv_2d_controller.md
CONV_2D_CONTROLLER -- requirements
Module: conv_2d_controller

Interface
REQ-001 Parameter IMG_W, default 28: image width and height in pixels (square image).
REQ-002 Parameter KER_W, default 5: kernel width and height (square kernel).
REQ-003 Parameter CONV_LAT, default 2: cycles from an image_input_valid beat to the matching conv_output_pixel.
REQ-004 Port clk  in  1: single clock; all logic on the rising edge.
REQ-005 Port rst  in  1: synchronous, active-high reset.
REQ-006 Port start  in  1: one-cycle request to run one full convolution.
REQ-007 Port pause  in  1: while high, no new memory address is issued.
REQ-008 Port busy  out  1: high while a run is in progress.
REQ-009 Port done  out  1: one-cycle pulse at the end of a run.
REQ-010 Port kmem_addr  out  5: kernel memory read address (read latency 1).
REQ-011 Port kmem_data  in  16: kernel memory read data.
REQ-012 Port imem_addr  out  10: image memory read address (read latency 1).
REQ-013 Port imem_data  in  16: image memory read data.
REQ-014 Ports kernal_input (out, 16), kernal_input_valid (out, 1), kernal_complete (out, 1): kernel load bus to conv_2d.
REQ-015 Ports image_input_pixel (out, 16), image_input_valid (out, 1), image_complete (out, 1): pixel stream to conv_2d.
REQ-016 Port conv_output_pixel  in  32: result from conv_2d.
REQ-017 Ports out_pixel (out, 32), out_valid (out, 1), out_row (out, 5), out_col (out, 5): qualified result and its output coordinates.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD_K, K_DONE, STREAM, FLUSH and DONE.
REQ-019 IDLE->LOAD_K SHALL occur when start=1 is sampled; start in any other state SHALL be ignored.
REQ-020 In LOAD_K, each non-paused cycle SHALL issue the next kmem_addr, 0..KER_W*KER_W-1, one address per cycle.
REQ-021 kernal_input_valid SHALL be high exactly one cycle after each issued kernel address, with kernal_input equal to kmem_data in that cycle.
REQ-022 After the last kernel address, the FSM SHALL enter K_DONE; kernal_complete SHALL pulse for one cycle, on the cycle after the last kernal_input_valid.
REQ-023 STREAM SHALL start the cycle after the kernal_complete pulse and SHALL issue imem_addr 0..IMG_W*IMG_W-1 in raster order, one per non-paused cycle.
REQ-024 image_input_valid and image_input_pixel SHALL follow each issued image address by one cycle, mirroring REQ-021.
REQ-025 image_complete SHALL pulse for one cycle, on the cycle after the last image_input_valid; the FSM SHALL then enter FLUSH.
REQ-026 FLUSH SHALL last CONV_LAT cycles; DONE SHALL then assert done for one cycle and return to IDLE.
REQ-027 busy SHALL be high from the cycle after start is accepted through the done cycle, inclusive.
REQ-028 While pause=1 in LOAD_K or STREAM, address counters SHALL hold, and the *_input_valid output SHALL be low one cycle later; pause SHALL be ignored in other states.
REQ-029 Each image beat SHALL carry a (row, col) tag; a beat with row>=KER_W-1 and col>=KER_W-1 SHALL set out_valid exactly CONV_LAT cycles later.
REQ-030 With each out_valid, the block SHALL drive out_pixel=conv_output_pixel, out_row=row-(KER_W-1) and out_col=col-(KER_W-1).
REQ-031 out_valid SHALL be high for exactly (IMG_W-KER_W+1)^2 cycles per run: 576 at the defaults.
REQ-032 Counters SHALL wrap only through the IDLE state; there SHALL be no carry past the last address.

Reset
REQ-033 When rst=1, the FSM SHALL go to IDLE, all counters and the valid delay line SHALL clear, and every output SHALL be 0 on the next edge.
REQ-034 rst SHALL take priority over start and pause, including reset mid-run; after reset, no residual out_valid or complete pulse SHALL appear.

Verification
REQ-035 Start sampled at cycle S, no pause -> kmem_addr 0..24 on S+1..S+25, kernal_input_valid on S+2..S+26, kernal_complete at S+27.
REQ-036 Same run -> imem_addr 0..783 on S+28..S+811, image_input_valid on S+29..S+812, image_complete at S+813, done at S+816, busy low at S+817.
REQ-037 Same run with imem holding pixel index p -> first out_valid at S+29+116+2 with row/col 0/0; last at S+814 with 23/23; 576 out_valid beats total.
REQ-038 pause high for 10 cycles mid-STREAM -> 10-cycle gap in image_input_valid, all later events shifted by 10, counts unchanged.
REQ-039 rst at S+400 -> all outputs 0 at S+401; a new start at S+410 reproduces REQ-035 timing relative to S+410.
REQ-040 start pulsed again at S+100 -> ignored; exactly one done and 576 out_valid beats.
